// File: rtl/leve1_trap_seq_if.sv
// rtl/leve1_trap_seq_if.sv - request, CSR-state and CSR-write-port bundle for leve1_trap_seq
//
// Purpose: groups every non-clock/reset signal of the trap sequencer.
//   slave  modport : the sequencer (consumes requests and CSR state, drives the CSR write port)
//   master modport : the surrounding pipeline / CSR file model
// Signals:
//   EXC_VALID/EXC_CAUSE/EXC_PC/EXC_TVAL  exception request from retire
//   XRET_VALID/XRET_S                    MRET (XRET_S=0) / SRET (XRET_S=1) request
//   PIPE_WCMD/PIPE_WA/PIPE_WD            pipeline CSR write
//   MSTATUS/MEDELEG/MTVEC/STVEC/MEPC/SEPC current CSR values
//   CSR_WCMD/CSR_WA/CSR_WD               arbitrated CSR write port
//   BUSY, REDIRECT_VALID/REDIRECT_PC, MODE
interface leve1_trap_seq_if #(
  parameter int XLEN = 64
);
  logic            EXC_VALID;
  logic [XLEN-1:0] EXC_CAUSE;
  logic [XLEN-1:0] EXC_PC;
  logic [XLEN-1:0] EXC_TVAL;
  logic            XRET_VALID;
  logic            XRET_S;
  logic [1:0]      PIPE_WCMD;
  logic [11:0]     PIPE_WA;
  logic [XLEN-1:0] PIPE_WD;
  logic [XLEN-1:0] MSTATUS;
  logic [XLEN-1:0] MEDELEG;
  logic [XLEN-1:0] MTVEC;
  logic [XLEN-1:0] STVEC;
  logic [XLEN-1:0] MEPC;
  logic [XLEN-1:0] SEPC;
  logic [1:0]      CSR_WCMD;
  logic [11:0]     CSR_WA;
  logic [XLEN-1:0] CSR_WD;
  logic            BUSY;
  logic            REDIRECT_VALID;
  logic [XLEN-1:0] REDIRECT_PC;
  logic [1:0]      MODE;

  modport slave (
    input  EXC_VALID, EXC_CAUSE, EXC_PC, EXC_TVAL, XRET_VALID, XRET_S,
           PIPE_WCMD, PIPE_WA, PIPE_WD,
           MSTATUS, MEDELEG, MTVEC, STVEC, MEPC, SEPC,
    output CSR_WCMD, CSR_WA, CSR_WD, BUSY, REDIRECT_VALID, REDIRECT_PC, MODE
  );

  modport master (
    output EXC_VALID, EXC_CAUSE, EXC_PC, EXC_TVAL, XRET_VALID, XRET_S,
           PIPE_WCMD, PIPE_WA, PIPE_WD,
           MSTATUS, MEDELEG, MTVEC, STVEC, MEPC, SEPC,
    input  CSR_WCMD, CSR_WA, CSR_WD, BUSY, REDIRECT_VALID, REDIRECT_PC, MODE
  );
endinterface

// File: rtl/leve1_trap_seq.sv
// rtl/leve1_trap_seq.sv - trap entry / xRET sequencer in front of the CSR write port
//
// Purpose: on an exception writes xEPC, xCAUSE, xTVAL, mstatus then redirects to
//   the trap vector; on MRET/SRET writes mstatus then redirects to xEPC. Outside a
//   sequence, pipeline CSR writes pass through with one cycle of latency.
// Ports:
//   CLK   clock
//   RSTn  asynchronous active-low reset
//   bus   leve1_trap_seq_if.slave (requests, CSR state, CSR write port, redirect, MODE)
// All outputs are registered.
`ifndef CSR_NONE
`define CSR_NONE 2'b00
`endif
`ifndef CSR_W
`define CSR_W 2'b01
`endif

module leve1_trap_seq #(
  parameter int         XLEN     = 64,
  parameter logic [1:0] RST_MODE = 2'b11
) (
  input  logic              CLK,
  input  logic              RSTn,
  leve1_trap_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR
  } state_t;

  typedef enum logic [1:0] {
    K_EXC, K_MRET, K_SRET
  } kind_t;

  state_t          state;
  kind_t           kind;
  logic            to_s;           // exception is delegated to S-mode
  logic [XLEN-1:0] snap_cause;
  logic [XLEN-1:0] snap_pc;
  logic [XLEN-1:0] snap_tval;
  logic [XLEN-1:0] snap_mstatus;
  logic [XLEN-1:0] snap_mtvec;
  logic [XLEN-1:0] snap_stvec;
  logic [XLEN-1:0] snap_mepc;
  logic [XLEN-1:0] snap_sepc;

  logic [1:0]      csr_wcmd_q;
  logic [11:0]     csr_wa_q;
  logic [XLEN-1:0] csr_wd_q;
  logic            busy_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [1:0]      mode_q;

  // Delegation only applies when the trap is taken from below M-mode.
  logic deleg_now;
  assign deleg_now = (mode_q != 2'b11) && bus.MEDELEG[bus.EXC_CAUSE[5:0]];

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] st,
                                                  input logic            s_tgt,
                                                  input logic [1:0]      cur_mode);
    logic [XLEN-1:0] r;
    r = st;
    if (s_tgt) begin
      r[5] = st[1];
      r[1] = 1'b0;
      r[8] = cur_mode[0];
    end else begin
      r[7]     = st[3];
      r[3]     = 1'b0;
      r[12:11] = cur_mode;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ret_status(input logic [XLEN-1:0] st,
                                                 input logic            is_s);
    logic [XLEN-1:0] r;
    r = st;
    if (is_s) begin
      r[1]  = st[5];
      r[5]  = 1'b1;
      r[8]  = 1'b0;
      r[17] = 1'b0;
    end else begin
      r[3]     = st[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b00;
      // Returning to M keeps MPRV; any lower mode clears it.
      if (st[12:11] != 2'b11) r[17] = 1'b0;
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state            <= IDLE;
      kind             <= K_EXC;
      to_s             <= 1'b0;
      snap_cause       <= '0;
      snap_pc          <= '0;
      snap_tval        <= '0;
      snap_mstatus     <= '0;
      snap_mtvec       <= '0;
      snap_stvec       <= '0;
      snap_mepc        <= '0;
      snap_sepc        <= '0;
      csr_wcmd_q       <= `CSR_NONE;
      csr_wa_q         <= '0;
      csr_wd_q         <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mode_q           <= RST_MODE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.EXC_VALID || bus.XRET_VALID) begin
            snap_cause   <= bus.EXC_CAUSE;
            snap_pc      <= bus.EXC_PC;
            snap_tval    <= bus.EXC_TVAL;
            snap_mstatus <= bus.MSTATUS;
            snap_mtvec   <= bus.MTVEC;
            snap_stvec   <= bus.STVEC;
            snap_mepc    <= bus.MEPC;
            snap_sepc    <= bus.SEPC;
            busy_q       <= 1'b1;
            csr_wcmd_q   <= `CSR_W;
          end
          if (bus.EXC_VALID) begin
            // The first write is issued straight from the live inputs, which
            // are the same values the snapshot captures this cycle.
            state    <= W_EPC;
            kind     <= K_EXC;
            to_s     <= deleg_now;
            csr_wa_q <= deleg_now ? 12'h141 : 12'h341;
            csr_wd_q <= {bus.EXC_PC[XLEN-1:1], 1'b0};
          end else if (bus.XRET_VALID) begin
            state    <= W_STATUS;
            kind     <= bus.XRET_S ? K_SRET : K_MRET;
            to_s     <= 1'b0;
            csr_wa_q <= 12'h300;
            csr_wd_q <= ret_status(bus.MSTATUS, bus.XRET_S);
          end else begin
            csr_wcmd_q <= bus.PIPE_WCMD;
            csr_wa_q   <= bus.PIPE_WA;
            csr_wd_q   <= bus.PIPE_WD;
          end
        end
        W_EPC: begin
          state    <= W_CAUSE;
          csr_wa_q <= to_s ? 12'h142 : 12'h342;
          csr_wd_q <= snap_cause;
        end
        W_CAUSE: begin
          state    <= W_TVAL;
          csr_wa_q <= to_s ? 12'h143 : 12'h343;
          csr_wd_q <= snap_tval;
        end
        W_TVAL: begin
          state    <= W_STATUS;
          csr_wa_q <= 12'h300;
          csr_wd_q <= trap_status(snap_mstatus, to_s, mode_q);
        end
        W_STATUS: begin
          state            <= REDIR;
          csr_wcmd_q       <= `CSR_NONE;
          redirect_valid_q <= 1'b1;
          case (kind)
            K_MRET: begin
              mode_q        <= snap_mstatus[12:11];
              redirect_pc_q <= snap_mepc;
            end
            K_SRET: begin
              mode_q        <= {1'b0, snap_mstatus[8]};
              redirect_pc_q <= snap_sepc;
            end
            default: begin
              mode_q        <= to_s ? 2'b01 : 2'b11;
              redirect_pc_q <= (to_s ? snap_stvec : snap_mtvec) & ~{{(XLEN-2){1'b0}}, 2'b11};
            end
          endcase
        end
        REDIR: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CSR_WCMD       = csr_wcmd_q;
  assign bus.CSR_WA         = csr_wa_q;
  assign bus.CSR_WD         = csr_wd_q;
  assign bus.BUSY           = busy_q;
  assign bus.REDIRECT_VALID = redirect_valid_q;
  assign bus.REDIRECT_PC    = redirect_pc_q;
  assign bus.MODE           = mode_q;

endmodule

// File: tb/tb_leve1_trap_seq.sv
// tb/tb_leve1_trap_seq.sv - directed self-checking bench for leve1_trap_seq
module tb_leve1_trap_seq;

  logic CLK;
  logic RSTn;
  int   n_err;
  int   n_checks;

  leve1_trap_seq_if #(.XLEN(64)) bus ();

  leve1_trap_seq #(.XLEN(64), .RST_MODE(2'b11)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.EXC_VALID  = 1'b0;
    bus.XRET_VALID = 1'b0;
    bus.XRET_S     = 1'b0;
    bus.PIPE_WCMD  = 2'b00;
  endtask

  // Request must already be presented; checks T+1..T+6 of an exception.
  task automatic exc_seq(input string tag, input logic s_side,
                         input logic [63:0] epc, input logic [63:0] cause,
                         input logic [63:0] tval, input logic [63:0] status,
                         input logic [63:0] rpc,
                         input logic [1:0] mode_before, input logic [1:0] mode_after);
    logic [11:0] b;
    b = s_side ? 12'h100 : 12'h300;
    step();
    clear_req();
    chk({tag, ".epc_cmd"}, 64'(bus.CSR_WCMD), 64'h1);
    chk({tag, ".epc_wa"},  64'(bus.CSR_WA), 64'(b | 12'h041));
    chk({tag, ".epc_wd"},  bus.CSR_WD, epc);
    chk({tag, ".busy1"},   64'(bus.BUSY), 64'h1);
    step();
    chk({tag, ".cause_wa"}, 64'(bus.CSR_WA), 64'(b | 12'h042));
    chk({tag, ".cause_wd"}, bus.CSR_WD, cause);
    step();
    chk({tag, ".tval_wa"}, 64'(bus.CSR_WA), 64'(b | 12'h043));
    chk({tag, ".tval_wd"}, bus.CSR_WD, tval);
    step();
    chk({tag, ".st_cmd"}, 64'(bus.CSR_WCMD), 64'h1);
    chk({tag, ".st_wa"},  64'(bus.CSR_WA), 64'h300);
    chk({tag, ".st_wd"},  bus.CSR_WD, status);
    chk({tag, ".mode4"},  64'(bus.MODE), 64'(mode_before));
    chk({tag, ".rv4"},    64'(bus.REDIRECT_VALID), 64'h0);
    step();
    chk({tag, ".redir_cmd"}, 64'(bus.CSR_WCMD), 64'h0);
    chk({tag, ".rv"},        64'(bus.REDIRECT_VALID), 64'h1);
    chk({tag, ".rpc"},       bus.REDIRECT_PC, rpc);
    chk({tag, ".busy5"},     64'(bus.BUSY), 64'h1);
    chk({tag, ".mode"},      64'(bus.MODE), 64'(mode_after));
    step();
    chk({tag, ".rv_off"},  64'(bus.REDIRECT_VALID), 64'h0);
    chk({tag, ".busy_off"}, 64'(bus.BUSY), 64'h0);
  endtask

  task automatic xret_seq(input string tag, input logic [63:0] status,
                          input logic [63:0] rpc, input logic [1:0] mode_after);
    step();
    clear_req();
    chk({tag, ".st_cmd"}, 64'(bus.CSR_WCMD), 64'h1);
    chk({tag, ".st_wa"},  64'(bus.CSR_WA), 64'h300);
    chk({tag, ".st_wd"},  bus.CSR_WD, status);
    chk({tag, ".busy1"},  64'(bus.BUSY), 64'h1);
    step();
    chk({tag, ".redir_cmd"}, 64'(bus.CSR_WCMD), 64'h0);
    chk({tag, ".rv"},   64'(bus.REDIRECT_VALID), 64'h1);
    chk({tag, ".rpc"},  bus.REDIRECT_PC, rpc);
    chk({tag, ".mode"}, 64'(bus.MODE), 64'(mode_after));
    chk({tag, ".busy2"}, 64'(bus.BUSY), 64'h1);
    step();
    chk({tag, ".rv_off"},   64'(bus.REDIRECT_VALID), 64'h0);
    chk({tag, ".busy_off"}, 64'(bus.BUSY), 64'h0);
  endtask

  task automatic present_exc(input logic [63:0] cause, input logic [63:0] pc,
                             input logic [63:0] tval);
    bus.EXC_VALID = 1'b1;
    bus.EXC_CAUSE = cause;
    bus.EXC_PC    = pc;
    bus.EXC_TVAL  = tval;
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    RSTn     = 1'b1;
    clear_req();
    bus.EXC_CAUSE = '0;
    bus.EXC_PC    = '0;
    bus.EXC_TVAL  = '0;
    bus.PIPE_WA   = '0;
    bus.PIPE_WD   = '0;
    bus.MSTATUS   = '0;
    bus.MEDELEG   = '0;
    bus.MTVEC     = '0;
    bus.STVEC     = '0;
    bus.MEPC      = '0;
    bus.SEPC      = '0;

    // Reset state
    #2 RSTn = 1'b0;
    #1;
    chk("rst.cmd",  64'(bus.CSR_WCMD), 64'h0);
    chk("rst.wa",   64'(bus.CSR_WA), 64'h0);
    chk("rst.wd",   bus.CSR_WD, 64'h0);
    chk("rst.busy", 64'(bus.BUSY), 64'h0);
    chk("rst.rv",   64'(bus.REDIRECT_VALID), 64'h0);
    chk("rst.rpc",  bus.REDIRECT_PC, 64'h0);
    chk("rst.mode", 64'(bus.MODE), 64'h3);
    step();
    step();
    RSTn = 1'b1;
    step();

    // M-mode exception, not delegated
    bus.MSTATUS = 64'h0A;
    bus.MTVEC   = 64'h8000_0003;
    present_exc(64'd2, 64'h8000_0101, 64'hDEAD);
    exc_seq("mexc", 1'b0, 64'h8000_0100, 64'd2, 64'hDEAD, 64'h1882,
            64'h8000_0000, 2'b11, 2'b11);

    // MRET to U, MPRV cleared
    bus.MSTATUS    = 64'h20080;
    bus.MEPC       = 64'h1000;
    bus.XRET_VALID = 1'b1;
    bus.XRET_S     = 1'b0;
    xret_seq("mret", 64'h88, 64'h1000, 2'b00);

    // Delegated exception from U to S
    bus.MSTATUS = 64'h2;
    bus.MEDELEG = 64'h100;
    bus.STVEC   = 64'h8020_0001;
    present_exc(64'd8, 64'h4000_0004, 64'h55);
    exc_seq("sexc", 1'b1, 64'h4000_0004, 64'd8, 64'h55, 64'h20,
            64'h8020_0000, 2'b00, 2'b01);

    // SRET to U
    bus.MSTATUS    = 64'h20022;
    bus.SEPC       = 64'h2222;
    bus.XRET_VALID = 1'b1;
    bus.XRET_S     = 1'b1;
    xret_seq("sret", 64'h22, 64'h2222, 2'b00);

    // Reset during W_CAUSE from U-mode
    bus.MEDELEG = 64'h0;
    bus.MSTATUS = 64'h0;
    present_exc(64'd2, 64'h6000_0000, 64'h1);
    step();
    clear_req();
    chk("abort.epc_wa", 64'(bus.CSR_WA), 64'h341);
    step();
    chk("abort.cause_wa", 64'(bus.CSR_WA), 64'h342);
    #2 RSTn = 1'b0;
    #1;
    chk("abort.cmd",  64'(bus.CSR_WCMD), 64'h0);
    chk("abort.wa",   64'(bus.CSR_WA), 64'h0);
    chk("abort.busy", 64'(bus.BUSY), 64'h0);
    chk("abort.rv",   64'(bus.REDIRECT_VALID), 64'h0);
    chk("abort.mode", 64'(bus.MODE), 64'h3);
    step();
    RSTn = 1'b1;
    step();
    chk("abort.rv_after",   64'(bus.REDIRECT_VALID), 64'h0);
    chk("abort.busy_after", 64'(bus.BUSY), 64'h0);

    // From M with MEDELEG all ones: not delegated
    bus.MEDELEG = '1;
    bus.MSTATUS = 64'h0;
    bus.MTVEC   = 64'h8000_0003;
    present_exc(64'd8, 64'h5000_0002, 64'h9);
    exc_seq("nodeleg", 1'b0, 64'h5000_0002, 64'd8, 64'h9, 64'h1800,
            64'h8000_0000, 2'b11, 2'b11);

    // EXC, XRET and a pipeline write in the same IDLE cycle
    bus.MEDELEG    = 64'h0;
    bus.MSTATUS    = 64'h8;
    bus.MTVEC      = 64'h104;
    bus.XRET_VALID = 1'b1;
    bus.XRET_S     = 1'b0;
    bus.PIPE_WCMD  = 2'b01;
    bus.PIPE_WA    = 12'h305;
    bus.PIPE_WD    = 64'hAAAA;
    present_exc(64'd5, 64'h3001, 64'h7);
    exc_seq("race", 1'b0, 64'h3000, 64'd5, 64'h7, 64'h1880,
            64'h104, 2'b11, 2'b11);
    chk("race.no305_cmd", 64'(bus.CSR_WCMD), 64'h0);
    step();
    chk("race.idle_cmd", 64'(bus.CSR_WCMD), 64'h0);

    // Pipeline write alone: one-cycle latency
    bus.PIPE_WCMD = 2'b10;
    bus.PIPE_WA   = 12'h305;
    bus.PIPE_WD   = 64'h1234;
    #1;
    chk("pipe.before", 64'(bus.CSR_WCMD), 64'h0);
    step();
    chk("pipe.cmd", 64'(bus.CSR_WCMD), 64'h2);
    chk("pipe.wa",  64'(bus.CSR_WA), 64'h305);
    chk("pipe.wd",  bus.CSR_WD, 64'h1234);
    chk("pipe.busy", 64'(bus.BUSY), 64'h0);
    bus.PIPE_WCMD = 2'b00;
    step();
    chk("pipe.off", 64'(bus.CSR_WCMD), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/leve1_trap_seq.md
Name: leve1_trap_seq

Overview:
- Trap/return sequencer in front of the single CSR write port of the LEVE1 CSR file.
- On a synchronous exception it performs the privileged-architecture trap entry as a sequence of CSR writes; on MRET/SRET it performs the status restore.
- It tracks the current privilege mode and issues the PC redirect.
- Outside sequences it passes pipeline CSR-instruction writes through, so it arbitrates the write port between the pipeline and itself.

Parameters:
XLEN, 64, data/address width of CSR values and PCs.
RST_MODE, 2'b11, privilege mode after reset (M).

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
EXC_VALID  in  1  one-cycle exception request from retire stage
EXC_CAUSE  in  XLEN  cause code (bit XLEN-1 = 0, exceptions only)
EXC_PC  in  XLEN  faulting PC
EXC_TVAL  in  XLEN  trap value
XRET_VALID  in  1  one-cycle MRET/SRET request
XRET_S  in  1  1 = SRET, 0 = MRET
PIPE_WCMD  in  2  pipeline CSR write command
PIPE_WA  in  12  pipeline CSR write address
PIPE_WD  in  XLEN  pipeline CSR write data
MSTATUS  in  XLEN  current mstatus read value
MEDELEG  in  XLEN  current medeleg
MTVEC, STVEC, MEPC, SEPC  in  XLEN each  current values
CSR_WCMD  out  2  to CSR file write command
CSR_WA  out  12  to CSR file write address
CSR_WD  out  XLEN  to CSR file write data
BUSY  out  1  sequence in progress; pipeline must stall
REDIRECT_VALID  out  1  one-cycle PC redirect
REDIRECT_PC  out  XLEN  redirect target
MODE  out  2  current privilege mode (0 U, 1 S, 3 M)

Behaviour:
- Reset (RSTn low, asynchronous, may occur mid-sequence): state IDLE; MODE = RST_MODE; CSR_WCMD = `CSR_NONE; CSR_WA = 0; CSR_WD = 0; BUSY = 0; REDIRECT_VALID = 0; REDIRECT_PC = 0; snapshots cleared. An aborted sequence leaves any partial CSR writes in place.
- All outputs are registered.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR.
- IDLE acceptance priority, sampled only in IDLE:
  - EXC_VALID first: go to W_EPC.
  - else XRET_VALID: go to W_STATUS.
  - else pipeline passthrough: CSR_W* <= PIPE_* next cycle (1-cycle latency).
- On accept, both pipeline write and XRET in the same cycle are dropped.
- Requests arriving in non-IDLE states are ignored; the pipeline holds them under BUSY.
- Accept at cycle T:
  - Snapshot cause, pc, tval, MSTATUS, MTVEC/STVEC/MEPC/SEPC.
  - Compute deleg = (MODE != 3) && MEDELEG[cause[5:0]]; target mode tm = deleg ? 1 : 3.
- Exception sequence, CSR_WCMD = `CSR_W in each write state:
  - T+1 W_EPC: WA 0x341 (M) / 0x141 (S), WD = pc with bit0 cleared.
  - T+2 W_CAUSE: WA 0x342/0x142, WD = cause.
  - T+3 W_TVAL: WA 0x343/0x143, WD = tval.
  - T+4 W_STATUS: WA 0x300, WD = snapshot with:
    - M target: mpie(7) = mie(3), mie = 0, mpp(12:11) = MODE.
    - S target: spie(5) = sie(1), sie = 0, spp(8) = MODE[0].
    - All other bits unchanged.
  - MODE <= tm at end of T+4.
  - T+5 REDIR: REDIRECT_VALID = 1, REDIRECT_PC = tvec & ~3 (MTVEC or STVEC snapshot); CSR_WCMD = `CSR_NONE.
  - T+6: IDLE.
  - BUSY = 1 during T+1..T+5.
- MRET, accept at T:
  - T+1 W_STATUS: WD with mie = mpie, mpie = 1, mpp = 0; mprv(17) = 0 if mpp != 3.
  - MODE <= old mpp.
  - T+2 REDIR: REDIRECT_PC = MEPC snapshot.
  - BUSY = 1 during T+1..T+2.
- SRET, accept at T:
  - T+1 W_STATUS: WD with sie = spie, spie = 1, spp = 0, mprv = 0.
  - MODE <= {0, old spp}.
  - T+2 REDIR: REDIRECT_PC = SEPC snapshot.
- Out of scope: privilege/legality checks (handled in decode); interrupts.

Test Plan:
- MODE = 3, MSTATUS.mie = 1, EXC cause 2, pc 0x8000_0101, tval 0xDEAD, MTVEC 0x8000_0003 -> exactly four writes on T+1..T+4:
  - 0x341 = 0x8000_0100
  - 0x342 = 2
  - 0x343 = 0xDEAD
  - 0x300 with mie = 0, mpie = 1, mpp = 3
  - Then REDIRECT_PC = 0x8000_0000 at T+5; MODE = 3; BUSY high 5 cycles.
- MODE = 0, MEDELEG bit8 set, cause 8, STVEC 0x8020_0001, sie = 1 -> writes to 0x141/0x142/0x143, then 0x300 with spie = 1, sie = 0, spp = 0; REDIRECT_PC = 0x8020_0000; MODE = 1.
- MODE = 3, MEDELEG all ones, cause 8 -> not delegated: M-side addresses, MODE stays 3.
- MRET with mpp = 0, mpie = 1, MEPC 0x1000 -> T+1 0x300 write with mie = 1, mpie = 1, mpp = 0; T+2 REDIRECT_PC = 0x1000; MODE = 0.
- EXC_VALID, XRET_VALID and a PIPE write to 0x305 in the same IDLE cycle -> only the exception sequence; no 0x305 write ever. A PIPE write alone in IDLE appears on CSR_W* one cycle later.
- RSTn low during W_CAUSE -> outputs at reset values immediately, MODE = 3, no redirect; next EXC after release runs a full sequence.
